dmem_ctrl: RTL and testbench

Data-memory access controller for the MEM stage. It takes the load/store request held in the EX/MEM pipeline register and runs it on a single-port data bus with a req/ack handshake. It handles byte enables, write-data replication, and read extraction with sign/zero extension. It raises the stall flag that the flow controller uses to freeze the pipeline registers until the access completes.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_align.sv | 64 ++++++
 rtl/dmem_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the data-memory controller
//
// Contents: access width codes, load/store codes, controller state encoding,
// and the alignment rule shared by the controller.

package dmem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    // 2'b11 is reserved and behaves as a word access everywhere

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bytes are never misaligned; halves need addr[0]=0; words (and the
    // reserved code) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (width)
            W_BYTE:  mis = 1'b0;
            W_HALF:  mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-lane steering for stores and load extraction
//
// Ports:
//   width, addr_lo, rw, wr_data  request side (live MEM-stage fields)
//   be, wdata                    byte enables and replicated store data
//   rsp_width, rsp_addr_lo,
//   rsp_rdtype, rdata            response side (registered request copy + bus data)
//   rd_data                      shifted and sign/zero-extended load result

module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic        rw,
    input  logic [31:0] wr_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  rsp_width,
    input  logic [1:0]  rsp_addr_lo,
    input  logic        rsp_rdtype,
    input  logic [31:0] rdata,
    output logic [31:0] rd_data
);

    logic [31:0] shifted;

    always_comb begin
        be = 4'b1111;
        case (width)
            W_BYTE:  be = 4'b0001 << addr_lo;
            W_HALF:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Store data is replicated across all lanes so the slave can pick any lane
    // selected by be; loads drive zero to keep the bus quiet.
    always_comb begin
        wdata = 32'h0;
        if (rw == RW_STORE) begin
            case (width)
                W_BYTE:  wdata = {4{wr_data[7:0]}};
                W_HALF:  wdata = {2{wr_data[15:0]}};
                default: wdata = wr_data;
            endcase
        end
    end

    assign shifted = rdata >> {rsp_addr_lo, 3'b000};

    // rdtype 1 = zero-extend, 0 = sign-extend
    always_comb begin
        rd_data = shifted;
        case (rsp_width)
            W_BYTE:  rd_data = rsp_rdtype ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            W_HALF:  rd_data = rsp_rdtype ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: rd_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage load/store controller on a req/ack data bus
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_*_i               request held in the EX/MEM pipeline register
//   fc_dmem_stall_o       freeze request to the flow controller (combinational)
//   mem_rd_data_o/valid_o registered load result and its one-cycle pulse
//   exc_misalign_o        misaligned request (combinational)
//   exc_bus_o             one-cycle pulse on bus error or timeout
//   bus_*_o               registered bus request fields
//   bus_ack_i/err_i/rdata_i bus response

module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_mtype_i,
    input  logic        mem_rw_i,
    input  logic [1:0]  mem_width_i,
    input  logic [31:0] mem_wr_data_i,
    input  logic        mem_rdtype_i,
    input  logic [31:0] mem_addr_i,
    output logic        fc_dmem_stall_o,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_rd_valid_o,
    output logic        exc_misalign_o,
    output logic        exc_bus_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req_width;
    logic [1:0]       req_addr_lo;
    logic             req_rdtype;

    logic             misaligned;
    logic             accept;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [31:0]      rd_extract;

    assign misaligned = is_misaligned(mem_width_i, mem_addr_i[1:0]);
    assign accept     = (state == ST_IDLE) && mem_mtype_i && !misaligned;

    assign exc_misalign_o  = (state == ST_IDLE) && mem_mtype_i && misaligned;
    // Low in RESP so the pipeline register advances at the end of that cycle.
    assign fc_dmem_stall_o = accept || (state == ST_BUSY);

    // Response side works from the registered copy: the live MEM-stage
    // fields are only guaranteed stable while the stall is asserted.
    dmem_align u_align (
        .width       (mem_width_i),
        .addr_lo     (mem_addr_i[1:0]),
        .rw          (mem_rw_i),
        .wr_data     (mem_wr_data_i),
        .be          (be_next),
        .wdata       (wdata_next),
        .rsp_width   (req_width),
        .rsp_addr_lo (req_addr_lo),
        .rsp_rdtype  (req_rdtype),
        .rdata       (bus_rdata_i),
        .rd_data     (rd_extract)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            req_width      <= W_BYTE;
            req_addr_lo    <= 2'b00;
            req_rdtype     <= 1'b0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= 32'h0;
            bus_be_o       <= 4'h0;
            bus_wdata_o    <= 32'h0;
            mem_rd_data_o  <= 32'h0;
            mem_rd_valid_o <= 1'b0;
            exc_bus_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_rw_i;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_be_o    <= be_next;
                        bus_wdata_o <= wdata_next;
                        req_width   <= mem_width_i;
                        req_addr_lo <= mem_addr_i[1:0];
                        req_rdtype  <= mem_rdtype_i;
                        cnt         <= '0;
                        state       <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (bus_ack_i || bus_err_i) begin
                        bus_req_o <= 1'b0;
                        state     <= ST_RESP;
                        if (bus_err_i) begin
                            exc_bus_o <= 1'b1;
                        end else if (bus_we_o == RW_LOAD) begin
                            mem_rd_data_o  <= rd_extract;
                            mem_rd_valid_o <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus_req_o <= 1'b0;
                        exc_bus_o <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    mem_rd_valid_o <= 1'b0;
                    exc_bus_o      <= 1'b0;
                    cnt            <= '0;
                    state          <= ST_IDLE;
                end

                default: begin
                    bus_req_o <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl

module tb_dmem_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_mtype = 1'b0;
    logic        mem_rw = 1'b0;
    logic [1:0]  mem_width = 2'b00;
    logic [31:0] mem_wr_data = 32'h0;
    logic        mem_rdtype = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        exc_mis;
    logic        exc_bus;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_mtype_i     (mem_mtype),
        .mem_rw_i        (mem_rw),
        .mem_width_i     (mem_width),
        .mem_wr_data_i   (mem_wr_data),
        .mem_rdtype_i    (mem_rdtype),
        .mem_addr_i      (mem_addr),
        .fc_dmem_stall_o (stall),
        .mem_rd_data_o   (rd_data),
        .mem_rd_valid_o  (rd_valid),
        .exc_misalign_o  (exc_mis),
        .exc_bus_o       (exc_bus),
        .bus_req_o       (bus_req),
        .bus_we_o        (bus_we),
        .bus_addr_o      (bus_addr),
        .bus_be_o        (bus_be),
        .bus_wdata_o     (bus_wdata),
        .bus_ack_i       (bus_ack),
        .bus_err_i       (bus_err),
        .bus_rdata_i     (bus_rdata)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  width;
        logic        rdtype;
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [31:0] rdata;
        int          wait_cyc;
        logic        ack;
        logic        err;
        logic        mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic        exc;
        logic [31:0] rd;
    } resp_t;

    int    n_chk  = 0;
    int    n_pass = 0;
    resp_t sb_q[$];
    logic [31:0] last_rd = 32'h0;
    vec_t  vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rw, input logic [1:0] width, input logic rdtype,
                                input logic [31:0] addr, input logic [31:0] wr_data,
                                input logic [31:0] rdata, input int wait_cyc,
                                input logic ack, input logic err, input logic mis,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_rd);
        vec_t v;
        v.rw = rw; v.width = width; v.rdtype = rdtype; v.addr = addr;
        v.wr_data = wr_data; v.rdata = rdata; v.wait_cyc = wait_cyc;
        v.ack = ack; v.err = err; v.mis = mis; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_rd = exp_rd;
        return v;
    endfunction

    // Scoreboard consumer: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (rd_valid || exc_bus)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {30'h0, rd_valid, exc_bus}, 32'h0);
            end else begin
                resp_t e;
                e = sb_q.pop_front();
                chk("resp_kind", {30'h0, rd_valid, exc_bus}, {30'h0, !e.exc, e.exc});
                if (!e.exc) chk("resp_rd_data", rd_data, e.rd);
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        bit    timeout;
        bit    exp_valid;
        int    n_busy;
        int    stall_cnt;
        resp_t r;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        mem_mtype = 1'b1; mem_rw = v.rw; mem_width = v.width; mem_rdtype = v.rdtype;
        mem_addr = v.addr; mem_wr_data = v.wr_data;
        #1;
        chk({tag, "_misalign"}, {31'h0, exc_mis}, {31'h0, v.mis});
        chk({tag, "_stall0"}, {31'h0, stall}, {31'h0, !v.mis});
        if (v.mis) begin
            @(posedge clk); #1;
            mem_mtype = 1'b0;
            chk({tag, "_mis_no_req"}, {31'h0, bus_req}, 32'h0);
            return;
        end
        timeout   = !v.ack && !v.err;
        exp_valid = (v.rw == 1'b0) && v.ack && !v.err;
        n_busy    = timeout ? TO : v.wait_cyc + 1;
        if (timeout || v.err || exp_valid) begin
            r.exc = !exp_valid;
            r.rd  = v.exp_rd;
            sb_q.push_back(r);
        end
        stall_cnt = 1;
        for (int c = 1; c <= n_busy; c++) begin
            @(negedge clk);
            if (c == n_busy && !timeout) begin
                bus_ack = v.ack; bus_err = v.err; bus_rdata = v.rdata;
            end else begin
                bus_rdata = $urandom;
            end
            #1;
            chk({tag, "_req"}, {31'h0, bus_req}, 32'h1);
            if (stall) stall_cnt++;
            if (c == 1 || c == n_busy) begin
                chk({tag, "_addr"}, bus_addr, {v.addr[31:2], 2'b00});
                chk({tag, "_we"}, {31'h0, bus_we}, {31'h0, v.rw});
                chk({tag, "_be"}, {28'h0, bus_be}, {28'h0, v.exp_be});
                chk({tag, "_wdata"}, bus_wdata, v.exp_wdata);
            end
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0;
        #1;
        if (exp_valid) last_rd = v.exp_rd;
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(n_busy + 1));
        chk({tag, "_resp_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_resp_req"}, {31'h0, bus_req}, 32'h0);
        chk({tag, "_resp_valid"}, {31'h0, rd_valid}, {31'h0, exp_valid});
        chk({tag, "_resp_exc"}, {31'h0, exc_bus}, {31'h0, !exp_valid && (timeout || v.err)});
        chk({tag, "_rd_hold"}, rd_data, last_rd);
        @(posedge clk); #1;
        mem_mtype = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'h0, bus_req}, 32'h0);
        chk({tag, "_we"}, {31'h0, bus_we}, 32'h0);
        chk({tag, "_addr"}, bus_addr, 32'h0);
        chk({tag, "_be"}, {28'h0, bus_be}, 32'h0);
        chk({tag, "_wdata"}, bus_wdata, 32'h0);
        chk({tag, "_rd"}, rd_data, 32'h0);
        chk({tag, "_valid"}, {31'h0, rd_valid}, 32'h0);
        chk({tag, "_exc"}, {31'h0, exc_bus}, 32'h0);
        chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    endtask

    initial begin
        //            rw   wd     rt    addr          wr_data       rdata         wait ack  err  mis  be       wdata         rd
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        32'h80FF_FFFF, 1, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h80FF_FFFF, 0, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h1234_ABCD, 32'h0,        1, 1'b1, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0401, 32'h0,        32'h0,         0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0,        32'h0,         0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0602, 32'h0,        32'h5555_AAAA, 1, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h0,        32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,        0, 1'b1, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_8001, 0, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h0,        32'hFFFF_8001));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'h0,         0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        32'hFEDC_0000, 3, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,        32'h0000_FEDC));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0704, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 1'b1, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,        32'h1357_9BDF, 0, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h1357_9BDF));

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // back-to-back loads: the second must be accepted in the IDLE right after RESP
        run_vec(vecs[0], 100);
        run_vec(vecs[2], 101);

        // ack/err while idle must be ignored
        @(negedge clk);
        bus_ack = 1'b1; bus_err = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0;
        #1;
        chk("idle_ack_valid", {31'h0, rd_valid}, 32'h0);
        chk("idle_ack_exc", {31'h0, exc_bus}, 32'h0);
        chk("idle_ack_req", {31'h0, bus_req}, 32'h0);

        // asynchronous reset in the middle of BUSY
        @(negedge clk);
        mem_mtype = 1'b1; mem_rw = 1'b1; mem_width = 2'b10; mem_addr = 32'h0000_0800;
        mem_wr_data = 32'h89AB_CDEF;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_busy_req", {31'h0, bus_req}, 32'h1);
        #2;
        mem_mtype = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = 32'h0;
        run_vec(vecs[8], 200);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
